// File: rtl/obi_wb_pkg.sv
// rtl/obi_wb_pkg.sv - shared types and constants for the OBI to Wishbone bridge
//
// Contents:
//   bridge_state_e     bridge FSM state encoding (IDLE, BUS, RESP)
//   ERR_RDATA_DEFAULT  default read data returned on a timed-out transfer
//   cnt_width()        timeout counter width: $clog2(timeout+1), minimum 1
package obi_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } bridge_state_e;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'h0000_0000;

  // The counter has to be able to hold TIMEOUT_CYCLES itself. A zero timeout
  // still needs a one-bit counter so that the declaration stays legal.
  function automatic int cnt_width(input int timeout_cycles);
    int w;
    w = $clog2(timeout_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/obi_wishbone_bridge.sv
// rtl/obi_wishbone_bridge.sv - single-outstanding OBI slave to Wishbone master bridge
//
// One transfer at a time: an OBI request is granted in IDLE, and the request
// is registered onto the Wishbone bus (BUS). The bridge waits for ack or for a
// timeout, then returns a one-cycle OBI response (RESP).
//
// Parameters:
//   PIPELINED       1 = pipelined Wishbone (stb for one cycle), 0 = classic (stb = cyc)
//   TIMEOUT_CYCLES  BUS cycles waited for ack before an error response; 0 = never
//   ERR_RDATA       read data returned with an error response
//
// Ports:
//   clk_core, rst_core          clock, synchronous active-high reset
//   obi_req_i / obi_gnt_o       request handshake (gnt is combinational)
//   obi_we_i, obi_be_i, obi_addr_i, obi_wdata_i   request attributes
//   obi_rvalid_o, obi_rdata_o, obi_err_o          one-cycle response
//   wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_dat_o   Wishbone master outputs
//   wb_dat_i, wb_ack_i          Wishbone read data and acknowledge
module obi_wishbone_bridge
  import obi_wb_pkg::*;
#(
  parameter int          PIPELINED      = 1,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic        clk_core,
  input  logic        rst_core,
  input  logic        obi_req_i,
  output logic        obi_gnt_o,
  input  logic        obi_we_i,
  input  logic [3:0]  obi_be_i,
  input  logic [31:0] obi_addr_i,
  input  logic [31:0] obi_wdata_i,
  output logic        obi_rvalid_o,
  output logic [31:0] obi_rdata_o,
  output logic        obi_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  localparam int                CNT_W         = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  bridge_state_e     state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              timeout_hit;

  // The counter value after this BUS cycle; reaching the limit ends the
  // transfer. Ack is tested first in the FSM, so an ack in the same cycle wins.
  assign cnt_next    = cnt + CNT_W'(1);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_next == TIMEOUT_LIMIT);

  assign obi_gnt_o = (state == ST_IDLE) && obi_req_i && !rst_core;

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_sel_o     <= '0;
      wb_addr_o    <= '0;
      wb_dat_o     <= '0;
      obi_rvalid_o <= 1'b0;
      obi_rdata_o  <= '0;
      obi_err_o    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          obi_rvalid_o <= 1'b0;
          if (obi_gnt_o) begin
            wb_we_o   <= obi_we_i;
            wb_sel_o  <= obi_be_i;
            wb_addr_o <= obi_addr_i;
            wb_dat_o  <= obi_wdata_i;
            wb_cyc_o  <= 1'b1;
            wb_stb_o  <= 1'b1;
            cnt       <= '0;
            state     <= ST_BUS;
          end
        end

        ST_BUS: begin
          if (wb_ack_i) begin
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            obi_rvalid_o <= 1'b1;
            obi_err_o    <= 1'b0;
            obi_rdata_o  <= wb_we_o ? 32'h0 : wb_dat_i;
            state        <= ST_RESP;
          end else if (timeout_hit) begin
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            obi_rvalid_o <= 1'b1;
            obi_err_o    <= 1'b1;
            obi_rdata_o  <= ERR_RDATA;
            state        <= ST_RESP;
          end else begin
            if (TIMEOUT_CYCLES != 0) begin
              cnt <= cnt_next;
            end
            // Pipelined mode issues the strobe once; classic keeps it with cyc.
            if (PIPELINED != 0) begin
              wb_stb_o <= 1'b0;
            end
          end
        end

        ST_RESP: begin
          obi_rvalid_o <= 1'b0;
          state        <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obi_wishbone_bridge.sv
// tb/tb_obi_wishbone_bridge.sv - directed self-checking bench for obi_wishbone_bridge
//
// Two bridges share every input: dut_p is pipelined with ERR_RDATA 0xDEADBEEF,
// dut_c is classic with the default ERR_RDATA. Both use TIMEOUT_CYCLES = 4.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_obi_wishbone_bridge;

  logic        clk_core = 1'b0;
  logic        rst_core;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] dat_in;
  logic        ack;

  logic        p_gnt, p_rvalid, p_err, p_cyc, p_stb, p_we;
  logic [31:0] p_rdata, p_addr, p_dat;
  logic [3:0]  p_sel;
  logic        c_gnt, c_rvalid, c_err, c_cyc, c_stb, c_we;
  logic [31:0] c_rdata, c_addr, c_dat;
  logic [3:0]  c_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk_core = ~clk_core;

  obi_wishbone_bridge #(.PIPELINED(1), .TIMEOUT_CYCLES(4), .ERR_RDATA(32'hDEAD_BEEF)) dut_p (
    .clk_core(clk_core), .rst_core(rst_core),
    .obi_req_i(req), .obi_gnt_o(p_gnt), .obi_we_i(we), .obi_be_i(be),
    .obi_addr_i(addr), .obi_wdata_i(wdata),
    .obi_rvalid_o(p_rvalid), .obi_rdata_o(p_rdata), .obi_err_o(p_err),
    .wb_cyc_o(p_cyc), .wb_stb_o(p_stb), .wb_we_o(p_we), .wb_sel_o(p_sel),
    .wb_addr_o(p_addr), .wb_dat_o(p_dat), .wb_dat_i(dat_in), .wb_ack_i(ack)
  );

  obi_wishbone_bridge #(.PIPELINED(0), .TIMEOUT_CYCLES(4)) dut_c (
    .clk_core(clk_core), .rst_core(rst_core),
    .obi_req_i(req), .obi_gnt_o(c_gnt), .obi_we_i(we), .obi_be_i(be),
    .obi_addr_i(addr), .obi_wdata_i(wdata),
    .obi_rvalid_o(c_rvalid), .obi_rdata_o(c_rdata), .obi_err_o(c_err),
    .wb_cyc_o(c_cyc), .wb_stb_o(c_stb), .wb_we_o(c_we), .wb_sel_o(c_sel),
    .wb_addr_o(c_addr), .wb_dat_o(c_dat), .wb_dat_i(dat_in), .wb_ack_i(ack)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_core);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_core);
  endtask

  initial begin
    rst_core = 1'b1; req = 1'b1; we = 1'b0; be = 4'hF; addr = '0; wdata = '0;
    dat_in = '0; ack = 1'b0;

    // Reset: gnt suppressed while reset is asserted, outputs cleared.
    next_cycle();
    sample();
    check_val("rst_gnt_p", p_gnt, 1'b0);
    check_val("rst_gnt_c", c_gnt, 1'b0);
    check_val("rst_cyc", p_cyc, 1'b0);
    check_val("rst_rvalid", p_rvalid, 1'b0);
    check_val("rst_rdata", p_rdata, 32'h0);
    next_cycle();
    rst_core = 1'b0; req = 1'b0;
    next_cycle();

    // Read, pipelined: ack two cycles after stb.
    req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h100;
    sample();
    check_val("rd_gnt", p_gnt, 1'b1);
    next_cycle();
    req = 1'b0;
    sample();
    check_val("rd_b1_cyc", p_cyc, 1'b1);
    check_val("rd_b1_stb", p_stb, 1'b1);
    check_val("rd_b1_addr", p_addr, 32'h100);
    check_val("rd_b1_gnt", p_gnt, 1'b0);
    next_cycle();
    sample();
    check_val("rd_b2_stb_p", p_stb, 1'b0);
    check_val("rd_b2_stb_c", c_stb, 1'b1);
    check_val("rd_b2_cyc", p_cyc, 1'b1);
    next_cycle();
    ack = 1'b1; dat_in = 32'hCAFE_BABE;
    sample();
    check_val("rd_b3_cyc", p_cyc, 1'b1);
    check_val("rd_b3_stb", p_stb, 1'b0);
    check_val("rd_b3_addr", p_addr, 32'h100);
    next_cycle();
    ack = 1'b0; dat_in = 32'h0;
    sample();
    check_val("rd_resp_cyc", p_cyc, 1'b0);
    check_val("rd_resp_rvalid", p_rvalid, 1'b1);
    check_val("rd_resp_rdata", p_rdata, 32'hCAFE_BABE);
    check_val("rd_resp_err", p_err, 1'b0);
    check_val("rd_resp_rvalid_c", c_rvalid, 1'b1);
    next_cycle();
    sample();
    check_val("rd_after_rvalid", p_rvalid, 1'b0);
    check_val("rd_hold_rdata", p_rdata, 32'hCAFE_BABE);

    // Write, classic: ack in the first BUS cycle.
    next_cycle();
    req = 1'b1; we = 1'b1; be = 4'b0011; addr = 32'h2004; wdata = 32'h1234_5678;
    sample();
    check_val("wr_gnt", c_gnt, 1'b1);
    next_cycle();
    req = 1'b0; ack = 1'b1;
    sample();
    check_val("wr_cyc", c_cyc, 1'b1);
    check_val("wr_stb", c_stb, 1'b1);
    check_val("wr_sel", c_sel, 4'b0011);
    check_val("wr_we", c_we, 1'b1);
    check_val("wr_addr", c_addr, 32'h2004);
    check_val("wr_dat", c_dat, 32'h1234_5678);
    next_cycle();
    ack = 1'b0;
    sample();
    check_val("wr_resp_cyc", c_cyc, 1'b0);
    check_val("wr_resp_stb", c_stb, 1'b0);
    check_val("wr_resp_rvalid", c_rvalid, 1'b1);
    check_val("wr_resp_rdata", c_rdata, 32'h0);
    check_val("wr_resp_err", c_err, 1'b0);

    // Timeout after four BUS cycles without ack.
    next_cycle();
    next_cycle();
    req = 1'b1; we = 1'b0; addr = 32'h300;
    sample();
    check_val("to_gnt", p_gnt, 1'b1);
    next_cycle();
    req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      sample();
      check_val($sformatf("to_b%0d_cyc_p", i), p_cyc, 1'b1);
      check_val($sformatf("to_b%0d_stb_c", i), c_stb, 1'b1);
      next_cycle();
    end
    sample();
    check_val("to_cyc_p", p_cyc, 1'b0);
    check_val("to_stb_c", c_stb, 1'b0);
    check_val("to_rvalid", p_rvalid, 1'b1);
    check_val("to_err_p", p_err, 1'b1);
    check_val("to_rdata_p", p_rdata, 32'hDEAD_BEEF);
    check_val("to_err_c", c_err, 1'b1);
    check_val("to_rdata_c", c_rdata, 32'h0);
    next_cycle();
    sample();
    check_val("to_after_rvalid", p_rvalid, 1'b0);
    check_val("to_hold_err", p_err, 1'b1);

    // Ack on the cycle the counter would reach the limit: ack wins.
    next_cycle();
    req = 1'b1;
    sample();
    check_val("edge_gnt", p_gnt, 1'b1);
    next_cycle();
    req = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    ack = 1'b1; dat_in = 32'h55AA_55AA;
    sample();
    check_val("edge_b4_cyc", p_cyc, 1'b1);
    next_cycle();
    ack = 1'b0;
    sample();
    check_val("edge_rvalid", p_rvalid, 1'b1);
    check_val("edge_err", p_err, 1'b0);
    check_val("edge_rdata", p_rdata, 32'h55AA_55AA);

    // Stray ack while idle has no effect.
    next_cycle();
    next_cycle();
    ack = 1'b1; dat_in = 32'h0BAD_0BAD;
    next_cycle();
    ack = 1'b0;
    sample();
    check_val("stray_cyc", p_cyc, 1'b0);
    check_val("stray_rvalid", p_rvalid, 1'b0);
    check_val("stray_rdata", p_rdata, 32'h55AA_55AA);

    // Back-to-back: req and ack held high, one grant every three cycles.
    next_cycle();
    req = 1'b1; ack = 1'b1; dat_in = 32'h0000_0077;
    for (int i = 0; i < 9; i++) begin
      sample();
      check_val($sformatf("b2b_%0d_gnt", i), p_gnt, (i % 3) == 0);
      check_val($sformatf("b2b_%0d_cyc", i), p_cyc, (i % 3) == 1);
      check_val($sformatf("b2b_%0d_rvalid", i), p_rvalid, (i % 3) == 2);
      next_cycle();
    end
    req = 1'b0; ack = 1'b0;
    next_cycle();
    next_cycle();

    // Reset in the second BUS cycle, late ack, then a normal transfer.
    req = 1'b1; we = 1'b0; addr = 32'h400;
    sample();
    check_val("rs_gnt", p_gnt, 1'b1);
    next_cycle();
    req = 1'b0;
    sample();
    check_val("rs_b1_cyc", p_cyc, 1'b1);
    next_cycle();
    rst_core = 1'b1;
    next_cycle();
    rst_core = 1'b0; ack = 1'b1; dat_in = 32'h1111_2222;
    sample();
    check_val("rs_cyc", p_cyc, 1'b0);
    check_val("rs_stb_c", c_stb, 1'b0);
    check_val("rs_addr", p_addr, 32'h0);
    check_val("rs_rvalid", p_rvalid, 1'b0);
    check_val("rs_rdata", p_rdata, 32'h0);
    next_cycle();
    ack = 1'b0;
    sample();
    check_val("rs_late_rvalid", p_rvalid, 1'b0);
    check_val("rs_late_cyc", p_cyc, 1'b0);
    next_cycle();
    req = 1'b1; addr = 32'h500;
    sample();
    check_val("rs_new_gnt", p_gnt, 1'b1);
    next_cycle();
    req = 1'b0; ack = 1'b1; dat_in = 32'h3333_4444;
    sample();
    check_val("rs_new_addr", p_addr, 32'h500);
    next_cycle();
    ack = 1'b0;
    sample();
    check_val("rs_new_rvalid", p_rvalid, 1'b1);
    check_val("rs_new_rdata", p_rdata, 32'h3333_4444);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/obi_wishbone_bridge.md
OBI_WISHBONE_BRIDGE -- requirements
Module: obi_wishbone_bridge

Interface
REQ-001 SHALL have parameter PIPELINED, default 1: 1 = pipelined Wishbone (stb one cycle); 0 = classic (stb held until ack).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 256: cycles waited for ack before error termination; 0 disables timeout.
REQ-003 SHALL have parameter ERR_RDATA, default 32'h0000_0000: rdata returned on timeout.
REQ-004 SHALL have ports (one clock; reset is synchronous and active-high):
 clk_core  in  1  core clock, all logic on rising edge
 rst_core  in  1  synchronous active-high reset
 obi_req_i  in  1  core request
 obi_gnt_o  out  1  request accepted this cycle
 obi_we_i  in  1  1 = write
 obi_be_i  in  4  byte enables
 obi_addr_i  in  32  byte address
 obi_wdata_i  in  32  write data
 obi_rvalid_o  out  1  response valid, one cycle
 obi_rdata_o  out  32  read data
 obi_err_o  out  1  response error (timeout)
 wb_cyc_o  out  1  Wishbone cycle
 wb_stb_o  out  1  Wishbone strobe
 wb_we_o  out  1  Wishbone write
 wb_sel_o  out  4  byte selects
 wb_addr_o  out  32  address
 wb_dat_o  out  32  write data
 wb_dat_i  in  32  read data
 wb_ack_i  in  1  transfer acknowledge

Function
REQ-005 SHALL implement FSM states IDLE, BUS, RESP.
REQ-006 SHALL assert obi_gnt_o combinationally only when state = IDLE and obi_req_i = 1; at most one outstanding transfer.
REQ-007 On grant SHALL register we/be/addr/wdata into wb_we_o/wb_sel_o/wb_addr_o/wb_dat_o and enter BUS; wb_cyc_o = 1 and wb_stb_o = 1 from the next cycle.
REQ-008 In BUS with PIPELINED = 1, wb_stb_o SHALL be high only in the first BUS cycle; wb_cyc_o SHALL stay high until ack or timeout.
REQ-009 In BUS with PIPELINED = 0, wb_stb_o SHALL equal wb_cyc_o until ack or timeout.
REQ-010 wb_ack_i in any BUS cycle, including the first, SHALL end the transfer: wb_cyc_o and wb_stb_o low next cycle, wb_dat_i captured into obi_rdata_o (reads only; writes return 0), state RESP.
REQ-011 In RESP SHALL assert obi_rvalid_o for exactly one cycle with obi_err_o = 0, then return to IDLE; next grant earliest in the following cycle.
REQ-012 Latency: grant in cycle N, ack in cycle M (M >= N+1) -> obi_rvalid_o in cycle M+1.
REQ-013 Timeout counter SHALL clear on entering BUS and increment each BUS cycle without ack; when it reaches TIMEOUT_CYCLES, cyc/stb SHALL drop next cycle and RESP SHALL present obi_err_o = 1, obi_rdata_o = ERR_RDATA.
REQ-014 Ack in the same cycle the counter reaches TIMEOUT_CYCLES SHALL win: normal response, obi_err_o = 0.
REQ-015 wb_ack_i outside BUS SHALL be ignored with no state or output change.
REQ-016 Registered Wishbone outputs SHALL be held stable for the whole BUS state.
REQ-017 obi_rdata_o and obi_err_o SHALL be valid only while obi_rvalid_o = 1 and SHALL hold their last value otherwise.

Reset
REQ-018 rst_core = 1 at a rising edge SHALL force state IDLE, counter 0, and all outputs 0 from the next cycle, including mid-transfer (transfer dropped, no rvalid).
REQ-019 obi_gnt_o SHALL be 0 while rst_core = 1.

Structure
REQ-020 State enum, ERR_RDATA default, and the counter width rule ($clog2(TIMEOUT_CYCLES+1), minimum 1) SHALL reside in shared package obi_wb_pkg.
REQ-021 SHALL be a single module without sub-modules, instantiated once for the instruction port and once for the data port.

Verification
REQ-022 Read, PIPELINED=1: req addr 0x100, wb_dat_i 0xCAFEBABE, ack 2 cycles after stb -> stb one cycle, cyc 3 cycles, rvalid with rdata 0xCAFEBABE, err 0.
REQ-023 Write, PIPELINED=0: addr 0x2004, be 4'b0011, wdata 0x12345678, ack in first BUS cycle -> stb = cyc for 1 cycle, sel 0011, rvalid next cycle, err 0.
REQ-024 Timeout: TIMEOUT_CYCLES=4, no ack -> cyc drops after 4 BUS cycles, rvalid with err 1, rdata ERR_RDATA.
REQ-025 Back-to-back: req held continuously, ack always on the first BUS cycle -> gnt one cycle every 3 cycles, no overlapping cyc.
REQ-026 Reset mid-transfer: rst_core in the second BUS cycle -> all outputs 0 next cycle, no rvalid, a late ack ignored, and a new request is granted normally.
